// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between instruction fetch and data access, one transaction in flight.
// Min latency request->resp_ok 3 cycles; requests held on the bus until bus_addr_ok.
module mem_bus_arbiter #(
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned AW         = 32
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          ireq_valid,
   input  logic [AW-1:0] ireq_addr,
   input  logic          iflush,
   input  logic          dreq_valid,
   input  logic [AW-1:0] dreq_addr,
   input  logic [3:0]    dreq_strobe,
   input  logic [2:0]    dreq_size,
   input  logic [31:0]   dreq_wdata,
   output logic          breq_valid,
   output logic [AW-1:0] breq_addr,
   output logic [3:0]    breq_strobe,
   output logic [2:0]    breq_size,
   output logic [31:0]   breq_wdata,
   input  logic          bus_addr_ok,
   input  logic          bus_data_ok,
   input  logic [31:0]   bus_rdata,
   output logic          iresp_ok,
   output logic [31:0]   iresp_data,
   output logic          dresp_ok,
   output logic [31:0]   dresp_data,
   output logic          i_busy,
   output logic          d_busy
);

   localparam logic [2:0] MSIZE4    = 3'd2;
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   typedef enum logic [2:0] {IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA} state_t;

   state_t     state;
   logic [3:0] starve_cnt;
   logic       discard;
   logic       grant_i;
   logic       grant_d;

   always_comb begin
      grant_i = 1'b0;
      grant_d = 1'b0;
      if (state == IDLE) begin
         grant_i = ireq_valid && !iflush && (!dreq_valid || starve_cnt == STARVE_LIM);
         grant_d = dreq_valid && !grant_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state       <= IDLE;
         starve_cnt  <= 4'd0;
         discard     <= 1'b0;
         breq_valid  <= 1'b0;
         breq_addr   <= '0;
         breq_strobe <= 4'd0;
         breq_size   <= 3'd0;
         breq_wdata  <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_i) begin
                  breq_valid  <= 1'b1;
                  breq_addr   <= ireq_addr;
                  breq_strobe <= 4'd0;
                  breq_size   <= MSIZE4;
                  breq_wdata  <= 32'd0;
                  state       <= I_ADDR;
               end else if (grant_d) begin
                  breq_valid  <= 1'b1;
                  breq_addr   <= dreq_addr;
                  breq_strobe <= dreq_strobe;
                  breq_size   <= dreq_size;
                  breq_wdata  <= dreq_wdata;
                  state       <= D_ADDR;
               end
               // Counts D grants that jumped ahead of a waiting fetch
               if (!ireq_valid || grant_i)
                  starve_cnt <= 4'd0;
               else if (grant_d && starve_cnt != STARVE_LIM)
                  starve_cnt <= starve_cnt + 4'd1;
            end
            I_ADDR: if (bus_addr_ok) begin
               breq_valid <= 1'b0;
               state      <= I_DATA;
            end
            D_ADDR: if (bus_addr_ok) begin
               breq_valid <= 1'b0;
               state      <= D_DATA;
            end
            I_DATA: if (bus_data_ok) state <= IDLE;
            D_DATA: if (bus_data_ok) state <= IDLE;
            default: state <= IDLE;
         endcase

         // A fetch already on the bus cannot be withdrawn, so its response is swallowed instead
         if (state == I_DATA && bus_data_ok)
            discard <= 1'b0;
         else if (iflush && (state == IDLE || state == I_ADDR || state == I_DATA))
            discard <= 1'b1;
      end
   end

   assign iresp_ok   = (state == I_DATA) && bus_data_ok && !discard && !iflush;
   assign iresp_data = iresp_ok ? bus_rdata : 32'd0;
   assign dresp_ok   = (state == D_DATA) && bus_data_ok;
   assign dresp_data = dresp_ok ? bus_rdata : 32'd0;
   assign i_busy     = ireq_valid && !iresp_ok;
   assign d_busy     = dreq_valid && !dresp_ok;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: inputs driven at negedge, outputs checked 1ns later.
module tb_mem_bus_arbiter;

   localparam logic [2:0] MSIZE4 = 3'd2;

   logic        clk = 1'b0;
   logic        resetn;
   logic        ireq_valid;
   logic [31:0] ireq_addr;
   logic        iflush;
   logic        dreq_valid;
   logic [31:0] dreq_addr;
   logic [3:0]  dreq_strobe;
   logic [2:0]  dreq_size;
   logic [31:0] dreq_wdata;
   logic        breq_valid;
   logic [31:0] breq_addr;
   logic [3:0]  breq_strobe;
   logic [2:0]  breq_size;
   logic [31:0] breq_wdata;
   logic        bus_addr_ok;
   logic        bus_data_ok;
   logic [31:0] bus_rdata;
   logic        iresp_ok;
   logic [31:0] iresp_data;
   logic        dresp_ok;
   logic [31:0] dresp_data;
   logic        i_busy;
   logic        d_busy;

   int n_checks = 0;
   int n_fail   = 0;

   mem_bus_arbiter #(.STARVE_MAX(2), .AW(32)) dut (
      .clk(clk), .resetn(resetn),
      .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .iflush(iflush),
      .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_strobe(dreq_strobe),
      .dreq_size(dreq_size), .dreq_wdata(dreq_wdata),
      .breq_valid(breq_valid), .breq_addr(breq_addr), .breq_strobe(breq_strobe),
      .breq_size(breq_size), .breq_wdata(breq_wdata),
      .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
      .iresp_ok(iresp_ok), .iresp_data(iresp_data), .dresp_ok(dresp_ok), .dresp_data(dresp_data),
      .i_busy(i_busy), .d_busy(d_busy)
   );

   always #5 clk = ~clk;

   task automatic clear_inputs();
      ireq_valid = 0; ireq_addr = 0; iflush = 0;
      dreq_valid = 0; dreq_addr = 0; dreq_strobe = 0; dreq_size = 0; dreq_wdata = 0;
      bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
   endtask

   task automatic apply_reset();
      @(negedge clk); clear_inputs(); resetn = 0;
      @(negedge clk);
      @(negedge clk); resetn = 1;
   endtask

   task automatic test_reset();
      @(negedge clk); clear_inputs(); resetn = 0;
      @(negedge clk); @(negedge clk); #1;
      n_checks++; if ({breq_valid, breq_addr, breq_strobe, breq_size, breq_wdata} !== '0) begin n_fail++; $display("FAIL reset_breq got v=%0h a=%0h s=%0h z=%0h w=%0h want all 0", breq_valid, breq_addr, breq_strobe, breq_size, breq_wdata); end
      n_checks++; if ({iresp_ok, dresp_ok, i_busy, d_busy} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {iresp_ok, dresp_ok, i_busy, d_busy}); end
      n_checks++; if ({iresp_data, dresp_data} !== 64'd0) begin n_fail++; $display("FAIL reset_rdata got %0h/%0h want 0/0", iresp_data, dresp_data); end
      resetn = 1;
   endtask

   task automatic test_fetch();
      apply_reset();
      ireq_valid = 1; ireq_addr = 32'hBFC00000; #1;
      n_checks++; if ({breq_valid, i_busy} !== 2'b01) begin n_fail++; $display("FAIL fetch_c0 got valid=%b busy=%b want 0/1", breq_valid, i_busy); end
      @(negedge clk); bus_addr_ok = 1; #1;
      n_checks++; if ({breq_valid, breq_addr, breq_strobe, breq_size} !== {1'b1, 32'hBFC00000, 4'b0000, MSIZE4}) begin n_fail++; $display("FAIL fetch_c1_breq got v=%b a=%0h s=%b z=%0d want 1/bfc00000/0000/%0d", breq_valid, breq_addr, breq_strobe, breq_size, MSIZE4); end
      @(negedge clk); bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h3C088000; #1;
      n_checks++; if ({iresp_ok, iresp_data, i_busy, dresp_ok} !== {1'b1, 32'h3C088000, 1'b0, 1'b0}) begin n_fail++; $display("FAIL fetch_c2_resp got ok=%b d=%0h busy=%b dok=%b want 1/3c088000/0/0", iresp_ok, iresp_data, i_busy, dresp_ok); end
      n_checks++; if (breq_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_c2_breq_drop got %b want 0", breq_valid); end
      @(negedge clk); clear_inputs(); #1;
      n_checks++; if ({iresp_ok, breq_valid} !== 2'b00) begin n_fail++; $display("FAIL fetch_idle got ok=%b v=%b want 0/0", iresp_ok, breq_valid); end
   endtask

   task automatic test_contention();
      apply_reset();
      ireq_valid = 1; ireq_addr = 32'hBFC00010;
      dreq_valid = 1; dreq_addr = 32'h80001004; dreq_strobe = 0; dreq_size = MSIZE4; dreq_wdata = 32'h0;
      @(negedge clk); bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'hFFFF0000; #1;
      n_checks++; if ({breq_valid, breq_addr, breq_strobe} !== {1'b1, 32'h80001004, 4'b0000}) begin n_fail++; $display("FAIL cont_d_first got v=%b a=%0h s=%b want 1/80001004/0000", breq_valid, breq_addr, breq_strobe); end
      n_checks++; if ({dresp_ok, iresp_ok} !== 2'b00) begin n_fail++; $display("FAIL cont_dataok_in_addr got dok=%b iok=%b want 0/0", dresp_ok, iresp_ok); end
      @(negedge clk); bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h11223344; #1;
      n_checks++; if ({dresp_ok, dresp_data, iresp_ok, d_busy, i_busy} !== {1'b1, 32'h11223344, 1'b0, 1'b0, 1'b1}) begin n_fail++; $display("FAIL cont_dresp got ok=%b d=%0h iok=%b db=%b ib=%b want 1/11223344/0/0/1", dresp_ok, dresp_data, iresp_ok, d_busy, i_busy); end
      @(negedge clk); bus_data_ok = 0; dreq_valid = 0; #1;
      n_checks++; if ({breq_valid, dresp_ok} !== 2'b00) begin n_fail++; $display("FAIL cont_idle got v=%b dok=%b want 0/0", breq_valid, dresp_ok); end
      @(negedge clk); bus_addr_ok = 1; #1;
      n_checks++; if ({breq_valid, breq_addr, breq_size} !== {1'b1, 32'hBFC00010, MSIZE4}) begin n_fail++; $display("FAIL cont_i_second got v=%b a=%0h z=%0d want 1/bfc00010/%0d", breq_valid, breq_addr, breq_size, MSIZE4); end
      @(negedge clk); bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h55667788; #1;
      n_checks++; if ({iresp_ok, iresp_data, dresp_ok} !== {1'b1, 32'h55667788, 1'b0}) begin n_fail++; $display("FAIL cont_iresp got ok=%b d=%0h dok=%b want 1/55667788/0", iresp_ok, iresp_data, dresp_ok); end
      @(negedge clk); clear_inputs();
   endtask

   task automatic test_starvation();
      string order;
      string expect_order;
      int    seen;
      apply_reset();
      expect_order = "DDIDDI";
      order = "";
      seen = 0;
      ireq_valid = 1; ireq_addr = 32'hBFC00020;
      dreq_valid = 1; dreq_addr = 32'h80002000; dreq_size = MSIZE4;
      bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'hCAFE0000;
      for (int cyc = 0; cyc < 40 && seen < 6; cyc++) begin
         @(negedge clk); #1;
         n_checks++; if (iresp_ok && dresp_ok) begin n_fail++; $display("FAIL starve_overlap got iok=1 dok=1 want not both at cycle %0d", cyc); end
         if (dresp_ok) begin order = {order, "D"}; seen++; end
         if (iresp_ok) begin order = {order, "I"}; seen++; end
      end
      n_checks++; if (order != expect_order) begin n_fail++; $display("FAIL starve_order got %s want %s", order, expect_order); end
      @(negedge clk); clear_inputs();
   endtask

   task automatic test_slow_bus();
      apply_reset();
      dreq_valid = 1; dreq_addr = 32'h80000002; dreq_strobe = 4'b1100; dreq_size = 3'd1; dreq_wdata = 32'hDEADBEEF;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); bus_addr_ok = (k == 3); #1;
         n_checks++; if ({breq_valid, breq_addr, breq_strobe, breq_size, breq_wdata} !== {1'b1, 32'h80000002, 4'b1100, 3'd1, 32'hDEADBEEF}) begin n_fail++; $display("FAIL slow_hold_%0d got v=%b a=%0h s=%b z=%0d w=%0h want 1/80000002/1100/1/deadbeef", k, breq_valid, breq_addr, breq_strobe, breq_size, breq_wdata); end
      end
      @(negedge clk); bus_addr_ok = 0; #1;
      n_checks++; if ({breq_valid, dresp_ok, d_busy} !== 3'b001) begin n_fail++; $display("FAIL slow_after_addr got v=%b dok=%b busy=%b want 0/0/1", breq_valid, dresp_ok, d_busy); end
      @(negedge clk); bus_data_ok = 1; bus_rdata = 32'h0; #1;
      n_checks++; if ({dresp_ok, d_busy, iresp_ok} !== 3'b100) begin n_fail++; $display("FAIL slow_dresp got ok=%b busy=%b iok=%b want 1/0/0", dresp_ok, d_busy, iresp_ok); end
      @(negedge clk); clear_inputs();
   endtask

   task automatic test_flush();
      apply_reset();
      ireq_valid = 1; ireq_addr = 32'h80000100;
      @(negedge clk); bus_addr_ok = 1;
      @(negedge clk); bus_addr_ok = 0; iflush = 1; #1;
      n_checks++; if ({iresp_ok, breq_valid} !== 2'b00) begin n_fail++; $display("FAIL flush_idata got ok=%b v=%b want 0/0", iresp_ok, breq_valid); end
      @(negedge clk); iflush = 0; ireq_addr = 32'h80000180; bus_data_ok = 1; bus_rdata = 32'hAAAA5555; #1;
      n_checks++; if ({iresp_ok, i_busy} !== 2'b01) begin n_fail++; $display("FAIL flush_discard got ok=%b busy=%b want 0/1", iresp_ok, i_busy); end
      @(negedge clk); bus_data_ok = 0; #1;
      n_checks++; if (breq_valid !== 1'b0) begin n_fail++; $display("FAIL flush_idle got v=%b want 0", breq_valid); end
      @(negedge clk); bus_addr_ok = 1; #1;
      n_checks++; if ({breq_valid, breq_addr} !== {1'b1, 32'h80000180}) begin n_fail++; $display("FAIL flush_regrant got v=%b a=%0h want 1/80000180", breq_valid, breq_addr); end
      @(negedge clk); bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h24210001; #1;
      n_checks++; if ({iresp_ok, iresp_data, i_busy} !== {1'b1, 32'h24210001, 1'b0}) begin n_fail++; $display("FAIL flush_new_resp got ok=%b d=%0h busy=%b want 1/24210001/0", iresp_ok, iresp_data, i_busy); end
      @(negedge clk); clear_inputs();
   endtask

   task automatic test_reset_mid();
      apply_reset();
      dreq_valid = 1; dreq_addr = 32'h80003000; dreq_size = MSIZE4;
      @(negedge clk); #1;
      n_checks++; if (breq_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_daddr got v=%b want 1", breq_valid); end
      resetn = 0; dreq_valid = 0;
      @(negedge clk); #1;
      n_checks++; if ({breq_valid, breq_addr, breq_strobe, breq_size, breq_wdata, iresp_ok, dresp_ok, i_busy, d_busy} !== '0) begin n_fail++; $display("FAIL rmid_outputs got v=%b a=%0h ok=%b%b busy=%b%b want all 0", breq_valid, breq_addr, iresp_ok, dresp_ok, i_busy, d_busy); end
      resetn = 1; bus_data_ok = 1; bus_rdata = 32'h12345678; #1;
      n_checks++; if ({dresp_ok, iresp_ok} !== 2'b00) begin n_fail++; $display("FAIL rmid_stray0 got dok=%b iok=%b want 0/0", dresp_ok, iresp_ok); end
      @(negedge clk); #1;
      n_checks++; if ({dresp_ok, iresp_ok, breq_valid} !== 3'b000) begin n_fail++; $display("FAIL rmid_stray1 got dok=%b iok=%b v=%b want 0/0/0", dresp_ok, iresp_ok, breq_valid); end
      @(negedge clk); clear_inputs();
   endtask

   initial begin
      clear_inputs();
      resetn = 0;
      test_reset();
      test_fetch();
      test_contention();
      test_starvation();
      test_slow_bus();
      test_flush();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one memory bus between instruction fetch (I side) and the memory stage's data access (D side, driven from m_vreq / m_write_data / m_data_size / m_valo).
- Serialises requests with one transaction in flight at a time.
- Holds each granted request stable on the bus until it is accepted, then routes the response back to its owner.
- Produces per-side busy signals that the hazard unit turns into F/M stalls.

Parameters:
- STARVE_MAX, 4, consecutive D grants allowed while an I request waits before I is forced next (1..15).
- AW, 32, address width.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous reset, active-low
- ireq_valid  in  1  fetch requests a word
- ireq_addr  in  AW  fetch address, word aligned
- iflush  in  1  discard the in-flight/pending fetch (branch or exception redirect)
- dreq_valid  in  1  M stage requests access (m_vreq)
- dreq_addr  in  AW  data address (m_newval3)
- dreq_strobe  in  4  byte write enables, 0000 = load (m_write_data)
- dreq_size  in  3  msize_t (m_data_size)
- dreq_wdata  in  32  store data (m_valo)
- breq_valid  out  1  bus request valid
- breq_addr  out  AW  bus address
- breq_strobe  out  4  bus write strobe (0000 for fetch)
- breq_size  out  3  bus size (MSIZE4 for fetch)
- breq_wdata  out  32  bus write data
- bus_addr_ok  in  1  bus accepted the request this cycle
- bus_data_ok  in  1  bus response valid this cycle
- bus_rdata  in  32  bus read data
- iresp_ok  out  1  fetch response pulse
- iresp_data  out  32  fetch data
- dresp_ok  out  1  data response pulse
- dresp_data  out  32  load data (to m_data)
- i_busy  out  1  I request pending or in flight, not yet answered
- d_busy  out  1  D request pending or in flight, not yet answered

Behaviour:
- FSM states: IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA.
- Reset (resetn=0 at posedge):
  - state=IDLE; latched request regs=0; starve_cnt=0; discard=0.
  - All outputs 0, including i_busy and d_busy.
  - A reset mid-transaction abandons the transaction. A bus_data_ok that arrives after reset is ignored.
- Grant is evaluated only in IDLE:
  - Only D valid: grant D.
  - Only I valid (and iflush=0): grant I.
  - Both valid: grant D unless starve_cnt==STARVE_MAX, in which case grant I.
- Granting D while I is valid increments starve_cnt (saturating). Granting I, or ireq_valid=0 in IDLE, clears it.
- On grant, the address, strobe, size and wdata are latched into registers and the FSM enters X_ADDR on the next cycle.
  - Fetch latches strobe=0000 and size=MSIZE4.
- In X_ADDR:
  - breq_valid=1 with the latched fields. The fields stay stable until bus_addr_ok is sampled 1.
  - Then go to X_DATA; breq_valid=0 from the next cycle.
- In X_DATA, on bus_data_ok:
  - The owner's resp_ok is driven high combinationally in the same cycle, and its resp_data=bus_rdata.
  - Next state is IDLE.
  - The other side's resp_ok stays 0.
- Minimum latency, request to resp_ok: 3 cycles (grant, addr, data) when addr_ok and data_ok each arrive on their first possible cycle. No back-to-back issue: IDLE always occupies one cycle between transactions.
- i_busy = ireq_valid & ~iresp_ok. d_busy = dreq_valid & ~dresp_ok.
  - Requesters hold valid and all fields until their resp_ok.
  - D fields are sampled only at grant.
- iflush:
  - In IDLE, I_ADDR or I_DATA: set discard=1. The transaction still completes on the bus, since a request already on the bus cannot be withdrawn.
  - When discard=1, the matching bus_data_ok gives iresp_ok=0. discard clears at that point.
  - If iflush is asserted in IDLE in the same cycle as ireq_valid, I is not granted.
  - iflush has no effect on a D transaction.
- If bus_addr_ok and bus_data_ok are both 1 in X_ADDR, data_ok is ignored. Only one outstanding transaction is allowed.
- bus_data_ok in IDLE or X_ADDR is ignored.
- dreq_strobe≠0 with dreq_valid is a store. dresp_ok still pulses, and dresp_data is don't-care.

Test Plan:
- Fetch alone:
  - Stimulus: ireq_addr=0xBFC00000, addr_ok and data_ok immediate, rdata=0x3C088000.
  - Required: breq_valid in cycle 1 with strobe=0000 and size=MSIZE4; iresp_ok in cycle 2 with data 0x3C088000; i_busy falls the same cycle.
- Contention:
  - Stimulus: ireq and dreq asserted together, dreq is a load of 0x80001004.
  - Required: D is granted first and dresp_ok returns bus_rdata; I is granted in the following IDLE; the two resp_ok pulses never overlap.
- Starvation:
  - Stimulus: STARVE_MAX=2, ireq held high, dreq re-asserted every transaction.
  - Required: grant order D, D, I, D, D, I.
- Slow bus:
  - Stimulus: store of 0xDEADBEEF with strobe=1100 to 0x80000002; addr_ok delayed 3 cycles.
  - Required: breq fields stay constant for 4 cycles; breq_valid drops after addr_ok; dresp_ok pulses on data_ok.
- Flush in flight:
  - Stimulus: iflush pulses during I_DATA.
  - Required: data_ok arrives and iresp_ok stays 0; a new ireq (addr 0x80000180) is then granted and answered normally.
- Reset mid-transaction:
  - Stimulus: resetn=0 during D_ADDR.
  - Required: all outputs are 0 in the next cycle; a stray bus_data_ok after reset produces no resp_ok.
